// File: rtl/char_position_ctrl.sv
// Character window position controller: latches direction request edges and
// commits at most one horizontal and one vertical step per frame tick.
module char_position_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] moveReq,
  input  logic [2:0] charSize,
  input  logic       frameTick,
  output logic [9:0] posHorStart,
  output logic [9:0] posHorEnd,
  output logic [8:0] posVerStart,
  output logic [8:0] posVerEnd,
  output logic [3:0] moveAck,
  output logic       busy
);

  localparam logic [10:0] HDR = 11'd640;
  localparam logic [10:0] VDR = 11'd400;
  localparam int LEFT  = 3;
  localparam int RIGHT = 2;
  localparam int UP    = 1;
  localparam int DOWN  = 0;

  typedef enum logic [1:0] {IDLE, APPLY_H, APPLY_V, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  req_prev_q;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  snap_q, snap_d;
  logic [3:0]  acc_q, acc_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  size_q, size_d;
  logic [10:0] hs_q, hs_d, vs_q, vs_d;
  logic [9:0]  hs_out_q, hs_out_d, he_out_q, he_out_d;
  logic [8:0]  vs_out_q, vs_out_d, ve_out_q, ve_out_d;

  logic [3:0]  rise, clr, m_new;
  logic [10:0] w_cur, h_cur, w_new, h_new;
  logic [10:0] he_calc, ve_calc, hc_calc, vc_calc;

  function automatic logic [10:0] step_dec(input logic [10:0] p, input logic [10:0] s,
                                           input logic [10:0] lim);
    return (p >= s) ? (p - s) : (p + lim - s);
  endfunction

  function automatic logic [10:0] step_inc(input logic [10:0] p, input logic [10:0] s,
                                           input logic [10:0] lim);
    return ((p + s) >= lim) ? (p + s - lim) : (p + s);
  endfunction

  function automatic logic [10:0] end_pos(input logic [10:0] p, input logic [10:0] s,
                                          input logic [10:0] lim);
    logic [10:0] e;
    e = p + s - 11'd1;
    return (e >= lim) ? (e - lim) : e;
  endfunction

  assign rise  = moveReq & ~req_prev_q;
  assign m_new = {1'b0, charSize} + 4'd1;
  assign w_cur = {4'b0, size_q, 3'b0};
  assign h_cur = {3'b0, size_q, 4'b0};
  assign w_new = {4'b0, m_new, 3'b0};
  assign h_new = {3'b0, m_new, 4'b0};
  assign hc_calc = (HDR - w_new) >> 1;
  assign vc_calc = (VDR - h_new) >> 1;

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    acc_d    = acc_q;
    ack_d    = '0;
    size_d   = size_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    hs_out_d = hs_out_q;
    he_out_d = he_out_q;
    vs_out_d = vs_out_q;
    ve_out_d = ve_out_q;
    clr      = '0;
    he_calc  = '0;
    ve_calc  = '0;

    case (state_q)
      IDLE: begin
        // Snapshot so an edge arriving with frameTick waits for the next frame.
        if (frameTick) begin
          snap_d  = pending_q;
          acc_d   = '0;
          state_d = APPLY_H;
        end
      end

      APPLY_H: begin
        if (m_new != size_q) begin
          size_d = m_new;
          hs_d   = hc_calc;
          vs_d   = vc_calc;
          clr    = 4'hF;
          snap_d = '0;
        end else begin
          clr[LEFT]  = snap_q[LEFT];
          clr[RIGHT] = snap_q[RIGHT];
          if (snap_q[LEFT] && !snap_q[RIGHT]) begin
            hs_d        = step_dec(hs_q, w_cur, HDR);
            acc_d[LEFT] = 1'b1;
          end else if (snap_q[RIGHT] && !snap_q[LEFT]) begin
            hs_d         = step_inc(hs_q, w_cur, HDR);
            acc_d[RIGHT] = 1'b1;
          end
        end
        state_d = APPLY_V;
      end

      APPLY_V: begin
        clr[UP]   = snap_q[UP];
        clr[DOWN] = snap_q[DOWN];
        if (snap_q[UP] && !snap_q[DOWN]) begin
          vs_d      = step_dec(vs_q, h_cur, VDR);
          acc_d[UP] = 1'b1;
        end else if (snap_q[DOWN] && !snap_q[UP]) begin
          vs_d        = step_inc(vs_q, h_cur, VDR);
          acc_d[DOWN] = 1'b1;
        end
        // Output registers load on entry to UPDATE so the new window and the
        // ack pulse are visible during the UPDATE cycle itself.
        he_calc  = end_pos(hs_q, w_cur, HDR);
        ve_calc  = end_pos(vs_d, h_cur, VDR);
        hs_out_d = hs_q[9:0];
        he_out_d = he_calc[9:0];
        vs_out_d = vs_d[8:0];
        ve_out_d = ve_calc[8:0];
        ack_d    = acc_d;
        state_d  = UPDATE;
      end

      UPDATE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_prev_q <= '0;
      pending_q  <= '0;
      snap_q     <= '0;
      acc_q      <= '0;
      ack_q      <= '0;
      size_q     <= 4'd1;
      hs_q       <= 11'd316;
      vs_q       <= 11'd192;
      hs_out_q   <= 10'd316;
      he_out_q   <= 10'd323;
      vs_out_q   <= 9'd192;
      ve_out_q   <= 9'd207;
    end else begin
      state_q    <= state_d;
      req_prev_q <= moveReq;
      pending_q  <= pending_d;
      snap_q     <= snap_d;
      acc_q      <= acc_d;
      ack_q      <= ack_d;
      size_q     <= size_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      hs_out_q   <= hs_out_d;
      he_out_q   <= he_out_d;
      vs_out_q   <= vs_out_d;
      ve_out_q   <= ve_out_d;
    end
  end

  assign posHorStart = hs_out_q;
  assign posHorEnd   = he_out_q;
  assign posVerStart = vs_out_q;
  assign posVerEnd   = ve_out_q;
  assign moveAck     = ack_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_char_position_ctrl.sv
// Scoreboard bench for char_position_ctrl: stimulus pushes expected frame
// results, a monitor pops and compares each time a frame sequence ends.
module tb_char_position_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] moveReq;
  logic [2:0] charSize;
  logic       frameTick;
  logic [9:0] posHorStart, posHorEnd;
  logic [8:0] posVerStart, posVerEnd;
  logic [3:0] moveAck;
  logic       busy;

  char_position_ctrl dut (
    .clk        (clk),
    .reset      (rst_n),
    .moveReq    (moveReq),
    .charSize   (charSize),
    .frameTick  (frameTick),
    .posHorStart(posHorStart),
    .posHorEnd  (posHorEnd),
    .posVerStart(posVerStart),
    .posVerEnd  (posVerEnd),
    .moveAck    (moveAck),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hs;
    int he;
    int vs;
    int ve;
    int ack;
    int lat;   // 0 = aborted sequence, latency not checked
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int hs, input int he, input int vs, input int ve,
                      input int ack, input int lat);
    exp_t e;
    e.hs = hs; e.he = he; e.vs = vs; e.ve = ve; e.ack = ack; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    moveReq = '0;
    frameTick = 1'b0;
    charSize = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input int idx);
    moveReq[idx] = 1'b1;
    tick();
    moveReq[idx] = 1'b0;
    tick();
  endtask

  task automatic frame();
    frameTick = 1'b1;
    tick();
    frameTick = 1'b0;
    repeat (5) tick();
  endtask

  // Monitor: a frame sequence ends when busy falls.
  initial begin
    int   busy_cycles;
    int   ack_cycles;
    int   ack_seen;
    logic busy_prev;
    exp_t e;
    busy_cycles = 0;
    ack_cycles = 0;
    ack_seen = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (moveAck != 4'b0) begin
        ack_cycles++;
        ack_seen = ack_seen | int'(moveAck);
      end
      if (busy_prev && !busy) begin
        frame_no++;
        $display("frame %0d: hs=%0d he=%0d vs=%0d ve=%0d ack=%b busy_cycles=%0d",
                 frame_no, posHorStart, posHorEnd, posVerStart, posVerEnd,
                 ack_seen[3:0], busy_cycles);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%0d required=0", frame_no);
        end else begin
          e = exp_q.pop_front();
          check("posHorStart", int'(posHorStart), e.hs);
          check("posHorEnd",   int'(posHorEnd),   e.he);
          check("posVerStart", int'(posVerStart), e.vs);
          check("posVerEnd",   int'(posVerEnd),   e.ve);
          check("moveAck",     ack_seen,          e.ack);
          check("ack_pulse_cycles", ack_cycles, (e.ack != 0) ? 1 : 0);
          if (e.lat != 0) check("busy_cycles", busy_cycles, e.lat);
        end
        busy_cycles = 0;
        ack_cycles = 0;
        ack_seen = 0;
      end
      busy_prev = busy;
    end
  end

  initial begin
    rst_n = 1'b0;
    moveReq = '0;
    charSize = '0;
    frameTick = 1'b0;
    do_reset();

    // Reset state
    check("rst_posHorStart", int'(posHorStart), 316);
    check("rst_posHorEnd",   int'(posHorEnd),   323);
    check("rst_posVerStart", int'(posVerStart), 192);
    check("rst_posVerEnd",   int'(posVerEnd),   207);
    check("rst_busy",        int'(busy),        0);
    check("rst_moveAck",     int'(moveAck),     0);

    // Left steps down to 4, then wrap and step back Right
    for (int k = 1; k <= 39; k++) begin
      pulse(3);
      push(316 - 8 * k, 323 - 8 * k, 192, 207, 8, 3);
      frame();
    end
    pulse(3);
    push(636, 3, 192, 207, 8, 3);
    frame();
    pulse(2);
    push(4, 11, 192, 207, 4, 3);
    frame();

    // Up steps down to 0, then wrap and step back Down
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      pulse(1);
      push(316, 323, 192 - 16 * k, 207 - 16 * k, 2, 3);
      frame();
    end
    pulse(1);
    push(316, 323, 384, 399, 2, 3);
    frame();
    pulse(0);
    push(316, 323, 0, 15, 1, 3);
    frame();

    // Opposing Left/Right cancel; a held Down level moves once only
    do_reset();
    pulse(3);
    pulse(2);
    moveReq[0] = 1'b1;
    tick();
    push(316, 323, 208, 223, 1, 3);
    frame();
    push(316, 323, 208, 223, 0, 3);
    frame();
    moveReq = '0;
    tick();

    // Size change recenters and drops the pending Left
    do_reset();
    charSize = 3'd1;
    pulse(3);
    push(312, 327, 184, 215, 0, 3);
    frame();
    push(312, 327, 184, 215, 0, 3);
    frame();

    // Reset during APPLY_V aborts the sequence
    do_reset();
    pulse(3);
    push(308, 315, 192, 207, 8, 3);
    frame();
    pulse(3);
    push(316, 323, 192, 207, 0, 0);
    frameTick = 1'b1;
    tick();
    frameTick = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_posHorStart", int'(posHorStart), 316);
    check("abort_posHorEnd",   int'(posHorEnd),   323);
    check("abort_busy",        int'(busy),        0);
    check("abort_moveAck",     int'(moveAck),     0);
    tick();
    rst_n = 1'b1;
    tick();

    // frameTick during busy is ignored; Up raised then carries to next frame
    push(316, 323, 192, 207, 0, 3);
    frameTick = 1'b1;
    tick();
    moveReq[1] = 1'b1;
    tick();
    frameTick = 1'b0;
    moveReq = '0;
    repeat (5) tick();
    push(316, 323, 176, 191, 2, 3);
    frame();

    // Request edge coincident with frameTick commits in the following frame
    push(316, 323, 176, 191, 0, 3);
    moveReq[2] = 1'b1;
    frameTick = 1'b1;
    tick();
    frameTick = 1'b0;
    moveReq = '0;
    repeat (5) tick();
    push(324, 331, 176, 191, 4, 3);
    frame();

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_position_ctrl.md
# char_position_ctrl

Synchronous controller that owns the on-screen character window position for the VGA text path. It captures debounced direction requests, holds them pending, and commits at most one horizontal and one vertical step per frame. Steps are applied only on the frame-boundary tick, so the pixel pipeline never sees a window change mid-frame. It outputs registered start/end coordinates, with wrap-around, for the pixel generator's active-region compare.

## Interface
- HDR, 640, horizontal display region in pixels
- VDR, 400, vertical display region in lines
- HAL, 8, unmagnified character width
- VAL, 16, unmagnified character height
- clk  in  1  pixel clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- moveReq  in  4  debounced level requests {Left, Right, Up, Down} = bits [3:0], synchronous to clk
- charSize  in  3  magnify select; magnify M = charSize + 1 (1..8)
- frameTick  in  1  one-cycle pulse at start of vertical blanking
- posHorStart  out  10  first active column
- posHorEnd  out  10  last active column
- posVerStart  out  9  first active line
- posVerEnd  out  9  last active line
- moveAck  out  4  one-cycle pulse per applied direction, same bit order as moveReq
- busy  out  1  high while the FSM is not IDLE

## Operation
- Per-frame geometry: W = HAL·M and H = VAL·M. Horizontal step = W, vertical step = H.
- Request capture: a rising edge on moveReq[i] (registered previous value) sets pending[i]. Holding a level high produces one request only.
- If a set and a clear of the same pending bit occur in one cycle, the set wins.
- Size capture: sizeReg holds the committed M. On frameTick, if charSize+1 ≠ sizeReg, the size change wins:
  - all pending bits are cleared, with no ack;
  - the window recenters: HS = (HDR−W)/2, VS = (VDR−H)/2.
- Opposing requests: if Left and Right are both pending at commit, both are cleared and there is no horizontal move and no ack. Up/Down are handled the same way.
- Left: HS = HS ≥ W ? HS−W : HS+HDR−W.
- Right: HS = HS+W ≥ HDR ? HS+W−HDR : HS+W.
- Up and Down use the same rules with VS, H and VDR.
- Ends: HE = HS+W−1, minus HDR if the result is ≥ HDR. VE = VS+H−1, minus VDR if the result is ≥ VDR.
- All arithmetic is 11-bit unsigned internally. Outputs are truncated to port width; the range is guaranteed by the rules above.
- FSM states:
  - IDLE: waits for frameTick, then goes to APPLY_H.
  - APPLY_H: resolves the size change and the horizontal move, then goes to APPLY_V.
  - APPLY_V: resolves the vertical move, then goes to UPDATE.
  - UPDATE: computes the end coordinates, registers all four outputs, pulses moveAck, then returns to IDLE.
- A frameTick arriving while not IDLE is ignored. Pending requests carry over to the next frame.
- Consumed pending bits clear in the state that applies them.

## Timing
- Reset values:
  - posHorStart = 316, posHorEnd = 323, posVerStart = 192, posVerEnd = 207 (centered, M = 1);
  - sizeReg = 1, pending = 0, moveAck = 0, busy = 0, FSM = IDLE.
- Latency: frameTick sampled at cycle T gives updated outputs and moveAck at T+3.
- busy is high during T+1 through T+3.
- Outputs are stable at all other times; they never change outside UPDATE.
- A request edge must be registered at least one cycle before frameTick to commit in that frame.
- A request edge in the same cycle as frameTick commits in the next frame.
- An asserted reset mid-sequence aborts it: outputs return to reset values and no ack pulse is emitted.

## Test plan
- Reset, one Left edge, then frameTick → at T+3 posHorStart = 308, posHorEnd = 315, moveAck = 4'b1000 for one cycle; vertical outputs unchanged.
- Horizontal wrap: step Left until posHorStart = 4, then Left once more → posHorStart = 636, posHorEnd = 3. A following Right → 4 / 11.
- Vertical wrap: step Up until posVerStart = 0, then Up → posVerStart = 384, posVerEnd = 399. A following Down → 0 / 15.
- Left and Right both pending, plus Down, then frameTick → horizontal unchanged, posVerStart = 208, moveAck = 4'b0001. A held moveReq level produces no second move on the next frameTick.
- Set charSize = 1 with Left pending, then frameTick → posHorStart = 312, posHorEnd = 327, posVerStart = 184, posVerEnd = 215, moveAck = 0, pending cleared.
- Assert reset during APPLY_V after a Left request → outputs 316/323/192/207 immediately, busy = 0, no ack. A frameTick during busy is ignored and a pending Up applies on the next frame.
